// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: four-digit BCD display bus from digit producers to the scan driver
interface seg7_scan_driver_if;
   logic       enable;
   logic [3:0] dig_0;
   logic [3:0] dig_1;
   logic [3:0] dig_2;
   logic [3:0] dig_3;
   logic [3:0] dp;
   modport master (output enable, dig_0, dig_1, dig_2, dig_3, dp);
   modport slave  (input  enable, dig_0, dig_1, dig_2, dig_3, dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-seg driver with per-frame snapshot and anti-ghost blanking
module seg7_scan_driver #(
   parameter int TICK_DIV  = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic               clk,
   input  logic               reset,
   seg7_scan_driver_if.slave  bus,
   output logic [3:0]         an,
   output logic [6:0]         seg,
   output logic               dp_n,
   output logic               frame_start
);
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    slot_q, slot_d;
   logic [3:0]    sh_q [4];
   logic [3:0]    sh_d [4];
   logic [3:0]    sh_dp_q, sh_dp_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_n_q, dp_n_d;
   logic          frame_start_q, frame_start_d;
   function automatic logic [6:0] decode(input logic [3:0] c);
      case (c)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         4'd15:   decode = 7'h7F;
         default: decode = 7'h3F;
      endcase
   endfunction
   // Advance the scan position, snapshot at frame start, and form the next display outputs
   always_comb begin
      cnt_d         = cnt_q;
      slot_d        = slot_q;
      sh_d          = sh_q;
      sh_dp_d       = sh_dp_q;
      an_d          = 4'b1111;
      seg_d         = 7'h7F;
      dp_n_d        = 1'b1;
      frame_start_d = 1'b0;
      if (bus.enable) begin
         cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
         slot_d = (cnt_q == LAST) ? slot_q + 2'd1 : slot_q;
         if (cnt_q == '0 && slot_q == 2'd0) begin
            sh_d[0]       = bus.dig_0;
            sh_d[1]       = bus.dig_1;
            sh_d[2]       = bus.dig_2;
            sh_d[3]       = bus.dig_3;
            sh_dp_d       = bus.dp;
            frame_start_d = 1'b1;
         end
         if (cnt_q >= BLANK) begin
            an_d   = ~(4'b0001 << slot_q);
            seg_d  = decode(sh_q[slot_q]);
            dp_n_d = ~sh_dp_q[slot_q];
         end
      end
   end
   // State and registered outputs; reset dominates enable
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         slot_q        <= 2'd0;
         sh_q          <= '{default: 4'hF};
         sh_dp_q       <= 4'h0;
         an_q          <= 4'b1111;
         seg_q         <= 7'h7F;
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         slot_q        <= slot_d;
         sh_q          <= sh_d;
         sh_dp_q       <= sh_dp_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_n_q        <= dp_n_d;
         frame_start_q <= frame_start_d;
      end
   end
   assign an          = an_q;
   assign seg         = seg_q;
   assign dp_n        = dp_n_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench for the scan driver (TICK_DIV=8, BLANK_CYC=2)
module tb_seg7_scan_driver;
   localparam int TD = 8;
   localparam int BC = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] an;
   logic [6:0] seg;
   logic dp_n, frame_start;
   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp_n;
      logic       fs;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int e = 0;
   int fs_seen = 0;
   logic [3:0] sn [4];
   logic [3:0] sdp = 4'h0;
   logic [3:0] prev_an = 4'hF;
   always #5 clk = ~clk;
   seg7_scan_driver_if bus();
   seg7_scan_driver #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .an(an), .seg(seg), .dp_n(dp_n), .frame_start(frame_start)
   );
   function automatic logic [6:0] dec(input logic [3:0] c);
      case (c)
         4'd0: dec = 7'h40;  4'd1: dec = 7'h79;  4'd2: dec = 7'h24;  4'd3: dec = 7'h30;
         4'd4: dec = 7'h19;  4'd5: dec = 7'h12;  4'd6: dec = 7'h02;  4'd7: dec = 7'h78;
         4'd8: dec = 7'h00;  4'd9: dec = 7'h10;  4'd15: dec = 7'h7F;
         default: dec = 7'h3F;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask
   task automatic step();
      exp_t x;
      int p, c;
      logic [1:0] s;
      x.an = 4'hF; x.seg = 7'h7F; x.dp_n = 1'b1; x.fs = 1'b0;
      if (reset) begin
         e = 0;
         for (int k = 0; k < 4; k++) sn[k] = 4'hF;
         sdp = 4'h0;
      end else if (bus.enable) begin
         p = e % (4 * TD);
         if (p == 0) begin
            sn[0] = bus.dig_0; sn[1] = bus.dig_1; sn[2] = bus.dig_2; sn[3] = bus.dig_3;
            sdp = bus.dp;
         end
         x.fs = (p == 0);
         s = 2'(p / TD);
         c = p % TD;
         if (c >= BC) begin
            x.an = ~(4'b0001 << s);
            x.seg = dec(sn[s]);
            x.dp_n = ~sdp[s];
         end
         e++;
      end
      q.push_back(x);
      @(posedge clk);
      #1;
      x = q.pop_front();
      chk("an", 12'(an), 12'(x.an));
      chk("seg", 12'(seg), 12'(x.seg));
      chk("dp_n", 12'(dp_n), 12'(x.dp_n));
      chk("frame_start", 12'(frame_start), 12'(x.fs));
      checks++;
      assert (an == 4'hF || prev_an == 4'hF || an == prev_an) else begin
         errors++;
         $error("FAIL ghost: observed an %b after %b expected a blank between digits", an, prev_an);
      end
      prev_an = an;
      fs_seen += int'(frame_start);
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   initial begin
      for (int k = 0; k < 4; k++) sn[k] = 4'hF;
      bus.enable = 1'b0;
      bus.dig_0 = 4'd4; bus.dig_1 = 4'd3; bus.dig_2 = 4'd2; bus.dig_3 = 4'd1;
      bus.dp = 4'b0010;
      run(2);
      reset = 1'b0;
      bus.enable = 1'b1;
      run(32);
      chk("fs_count_frame1", 12'(fs_seen), 12'd1);
      run(16);
      bus.dig_0 = 4'd9;
      run(16);
      run(32);
      bus.dig_1 = 4'd15;
      bus.dig_2 = 4'd12;
      run(32);
      for (int code = 0; code < 10; code++) begin
         bus.dig_0 = 4'(code);
         run(32);
      end
      run(12);
      bus.enable = 1'b0;
      run(5);
      bus.enable = 1'b1;
      run(20);
      chk("fs_no_extra", 12'(fs_seen), 12'd15);
      run(32);
      run(28);
      reset = 1'b1;
      run(1);
      reset = 1'b0;
      run(128);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
